alarm_trigger: RTL and testbench

Upstream controller for the piezo melody stage. Compares live clock time against a stored alarm time and drives the level signal ALARM that starts and stops the melody player. Handles enable, stop, snooze with a bounded count, and auto-timeout of an unanswered alarm. Sits between the timekeeping counter and the piezo output block.

---
 rtl/chrono_pkg.sv | 26 ++
 rtl/sec_countdown.sv | 30 +++
 rtl/alarm_trigger.sv | 167 ++++++++++++++++
 tb/tb_alarm_trigger.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared clock/alarm types: FSM states, time field widths and range limits.
// Used by alarm_trigger and the second-countdown helper.
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZING
  } state_t;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int CNT_W    = 16;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  function automatic logic time_ok(
    input logic [HOUR_W-1:0] h,
    input logic [MIN_W-1:0]  m
  );
    return (h <= HOUR_W'(MAX_HOUR)) && (m <= MIN_W'(MAX_MIN));
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// 16-bit seconds down-counter: load wins over tick, saturates at zero,
// done is a registered pulse on the tick that reaches zero.
module sec_countdown
  import chrono_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= value;
      end else if (tick && count != '0) begin
        count <= count - 1'b1;
        done  <= (count == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm compare/ring/snooze controller driving the piezo ALARM level.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger
  import chrono_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int DEFAULT_HOUR   = 7,
  parameter int DEFAULT_MIN    = 0
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              TICK_1HZ,
  input  logic [HOUR_W-1:0] CUR_HOUR,
  input  logic [MIN_W-1:0]  CUR_MIN,
  input  logic [SEC_W-1:0]  CUR_SEC,
  input  logic [HOUR_W-1:0] SET_HOUR,
  input  logic [MIN_W-1:0]  SET_MIN,
  input  logic              SET_LOAD,
  input  logic              ALARM_EN,
  input  logic              BTN_STOP,
  input  logic              BTN_SNOOZE,
  output logic              ALARM,
  output logic              SNOOZE_ACTIVE,
  output logic [2:0]        SNOOZE_LEFT,
  output logic [HOUR_W-1:0] ALARM_HOUR,
  output logic [MIN_W-1:0]  ALARM_MIN
);

  localparam logic [CNT_W-1:0] RING_V = CNT_W'(RING_SECONDS);

  state_t           state;
  state_t           nxt;
  logic             match;
  logic             match_q;
  logic             trig;
  logic             set_ok;
  logic             cnt_load;
  logic             cnt_tick;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             done;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNZ_V   = CNT_W'(SNOOZE_SECONDS);
  localparam logic [2:0]       SNZ_MAX = 3'(MAX_SNOOZE);
  logic [2:0] left;
  logic [2:0] left_nxt;
`else
  localparam int unused_cfg = SNOOZE_SECONDS + MAX_SNOOZE;
  logic unused_snooze;
  assign unused_snooze = BTN_SNOOZE;
`endif

  assign match = (CUR_HOUR == ALARM_HOUR)
               & (CUR_MIN == ALARM_MIN)
               & (CUR_SEC == '0);
  assign trig   = match & ~match_q;
  assign set_ok = SET_LOAD & time_ok(SET_HOUR, SET_MIN);

  sec_countdown u_cnt (
    .clk   (CLK),
    .rst_n (RESETN),
    .load  (cnt_load),
    .value (cnt_val),
    .tick  (cnt_tick),
    .count (cnt),
    .done  (done)
  );

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = RING_V;
    cnt_tick = 1'b0;
`ifdef ALARM_SNOOZE_EN
    left_nxt = left;
`endif
    if (!ALARM_EN) begin
      nxt = IDLE;
    end else if (set_ok && (state == RINGING || state == SNOOZING)) begin
      nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
      left_nxt = SNZ_MAX;
`endif
    end else begin
      unique case (state)
        IDLE: nxt = ARMED;
        ARMED: begin
          if (trig) begin
            nxt      = RINGING;
            cnt_load = 1'b1;
`ifdef ALARM_SNOOZE_EN
            left_nxt = SNZ_MAX;
`endif
          end
        end
        RINGING: begin
          if (BTN_STOP) begin
            nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (BTN_SNOOZE && left != 3'd0) begin
            nxt      = SNOOZING;
            cnt_load = 1'b1;
            cnt_val  = SNZ_V;
            left_nxt = left - 3'd1;
`endif
          end else if (done) begin
            nxt = ARMED;
          end else begin
            cnt_tick = TICK_1HZ && (cnt != '0);
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZING: begin
          if (BTN_STOP) begin
            nxt = ARMED;
          end else if (done) begin
            nxt      = RINGING;
            cnt_load = 1'b1;
          end else begin
            cnt_tick = TICK_1HZ && (cnt != '0);
          end
        end
`endif
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      ALARM      <= 1'b0;
      match_q    <= 1'b0;
      ALARM_HOUR <= HOUR_W'(DEFAULT_HOUR);
      ALARM_MIN  <= MIN_W'(DEFAULT_MIN);
    end else begin
      state   <= nxt;
      ALARM   <= (nxt == RINGING);
      match_q <= match;
      if (ALARM_EN && set_ok) begin
        ALARM_HOUR <= SET_HOUR;
        ALARM_MIN  <= SET_MIN;
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      SNOOZE_ACTIVE <= 1'b0;
      left          <= SNZ_MAX;
    end else begin
      SNOOZE_ACTIVE <= (nxt == SNOOZING);
      left          <= left_nxt;
    end
  end

  assign SNOOZE_LEFT = left;
`else
  assign SNOOZE_ACTIVE = 1'b0;
  assign SNOOZE_LEFT   = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with short ring/snooze timings.
// Expectations follow ALARM_SNOOZE_EN when it is defined for the build.
module tb_alarm_trigger;

`ifdef ALARM_SNOOZE_EN
  localparam logic [2:0] ML  = 3'd3;
  localparam bit         SNZ = 1'b1;
`else
  localparam logic [2:0] ML  = 3'd0;
  localparam bit         SNZ = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [4:0] cur_h;
  logic [5:0] cur_m;
  logic [5:0] cur_s;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic       set_ld;
  logic       en;
  logic       stp;
  logic       snz;
  logic       alarm;
  logic       active;
  logic [2:0] left;
  logic [4:0] ahour;
  logic [5:0] amin;

  int checks;
  int fails;

  alarm_trigger #(
    .RING_SECONDS   (4),
    .SNOOZE_SECONDS (3),
    .MAX_SNOOZE     (3),
    .DEFAULT_HOUR   (7),
    .DEFAULT_MIN    (0)
  ) dut (
    .CLK           (clk),
    .RESETN        (rst_n),
    .TICK_1HZ      (tick),
    .CUR_HOUR      (cur_h),
    .CUR_MIN       (cur_m),
    .CUR_SEC       (cur_s),
    .SET_HOUR      (set_h),
    .SET_MIN       (set_m),
    .SET_LOAD      (set_ld),
    .ALARM_EN      (en),
    .BTN_STOP      (stp),
    .BTN_SNOOZE    (snz),
    .ALARM         (alarm),
    .SNOOZE_ACTIVE (active),
    .SNOOZE_LEFT   (left),
    .ALARM_HOUR    (ahour),
    .ALARM_MIN     (amin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ld;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [4:0] ch;
    logic [5:0] cm;
    logic [5:0] cs;
    logic       tk;
    logic       st;
    logic       sz;
    logic       ea;
    logic       es;
    logic [2:0] el;
    logic [4:0] eh;
    logic [5:0] em;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ea, input logic es,
                         input logic [2:0] el, input logic [4:0] eh,
                         input logic [5:0] em);
    chk({tag, ".alarm"}, int'(alarm), int'(ea));
    chk({tag, ".active"}, int'(active), int'(es));
    chk({tag, ".left"}, int'(left), int'(el));
    chk({tag, ".hour"}, int'(ahour), int'(eh));
    chk({tag, ".min"}, int'(amin), int'(em));
  endtask

  task automatic idle_in();
    tick = 0; set_ld = 0; stp = 0; snz = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cur(input logic [4:0] h, input logic [5:0] m);
    cur_h = h; cur_m = m; cur_s = 6'd0;
  endtask

  function automatic vec_t mk(
    input logic en_i, input logic ld_i, input int sh_i, input int sm_i,
    input int ch_i, input int cm_i, input int cs_i,
    input logic tk_i, input logic st_i, input logic sz_i,
    input logic ea_i, input logic es_i, input logic [2:0] el_i,
    input int eh_i, input int em_i);
    vec_t v;
    v.en = en_i; v.ld = ld_i; v.sh = 5'(sh_i); v.sm = 6'(sm_i);
    v.ch = 5'(ch_i); v.cm = 6'(cm_i); v.cs = 6'(cs_i);
    v.tk = tk_i; v.st = st_i; v.sz = sz_i;
    v.ea = ea_i; v.es = es_i; v.el = el_i;
    v.eh = 5'(eh_i); v.em = 6'(em_i);
    return v;
  endfunction

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    set_h  = '0;
    set_m  = '0;
    cur(5'd0, 6'd0);
    idle_in();

    // en ld  sh sm   ch cm cs  tk st sz   alarm act left  hr mn
    vecs[0]  = mk(1, 0,  0,  0, 12,  0, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[1]  = mk(1, 0,  0,  0,  7,  0, 0, 0, 0, 0, 1, 0, ML, 7,  0);
    vecs[2]  = mk(1, 0,  0,  0,  7,  0, 0, 1, 0, 0, 1, 0, ML, 7,  0);
    vecs[3]  = mk(1, 0,  0,  0,  7,  0, 0, 1, 0, 0, 1, 0, ML, 7,  0);
    vecs[4]  = mk(1, 0,  0,  0,  7,  0, 0, 1, 0, 0, 1, 0, ML, 7,  0);
    vecs[5]  = mk(1, 0,  0,  0,  7,  0, 0, 1, 0, 0, 1, 0, ML, 7,  0);
    vecs[6]  = mk(1, 0,  0,  0,  7,  0, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[7]  = mk(1, 0,  0,  0,  7,  0, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[8]  = mk(1, 0,  0,  0,  7,  0, 0, 1, 0, 0, 0, 0, ML, 7,  0);
    vecs[9]  = mk(1, 0,  0,  0,  7,  1, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[10] = mk(1, 0,  0,  0,  7,  0, 0, 0, 0, 0, 1, 0, ML, 7,  0);
    vecs[11] = mk(1, 0,  0,  0,  7,  0, 0, 1, 1, 1, 0, 0, ML, 7,  0);
    vecs[12] = mk(1, 1, 24, 10,  7,  0, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[13] = mk(1, 1,  6, 30, 12,  0, 0, 0, 0, 0, 0, 0, ML, 6, 30);
    vecs[14] = mk(1, 0,  0,  0,  6, 30, 0, 0, 0, 0, 1, 0, ML, 6, 30);
    vecs[15] = mk(1, 1,  7,  0,  6, 30, 0, 0, 0, 0, 0, 0, ML, 7,  0);
    vecs[16] = mk(0, 0,  0,  0,  6, 30, 0, 0, 0, 0, 0, 0, ML, 7,  0);

    step();
    step();
    chk_all("reset", 1'b0, 1'b0, ML, 5'd7, 6'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en; set_ld = vecs[i].ld;
      set_h = vecs[i].sh; set_m = vecs[i].sm;
      cur_h = vecs[i].ch; cur_m = vecs[i].cm; cur_s = vecs[i].cs;
      tick = vecs[i].tk; stp = vecs[i].st; snz = vecs[i].sz;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].es,
              vecs[i].el, vecs[i].eh, vecs[i].em);
    end
    idle_in();

    // snooze cycles until exhausted, then one more press
    en = 1; cur(5'd5, 6'd0); step();
    cur(5'd7, 6'd0); step();
    chk_all("snz.ring", 1'b1, 1'b0, ML, 5'd7, 6'd0);
    for (int k = 0; k < 3; k++) begin
      snz = 1; step(); snz = 0;
      if (SNZ) begin
        chk_all($sformatf("snz%0d.press", k), 1'b0, 1'b1,
                3'(2 - k), 5'd7, 6'd0);
        for (int t = 0; t < 3; t++) begin
          tick = 1; step();
        end
        tick = 0;
        chk($sformatf("snz%0d.waiting", k), int'(alarm), 0);
        step();
        chk($sformatf("snz%0d.rering", k), int'(alarm), 1);
        chk($sformatf("snz%0d.active", k), int'(active), 0);
      end else begin
        chk_all($sformatf("snz%0d.ignored", k), 1'b1, 1'b0,
                3'd0, 5'd7, 6'd0);
      end
    end
    snz = 1; step(); snz = 0;
    chk_all("snz.exhausted", 1'b1, 1'b0, 3'd0, 5'd7, 6'd0);
    stp = 1; step(); stp = 0;
    chk_all("snz.stop", 1'b0, 1'b0, 3'd0, 5'd7, 6'd0);

    // enable dropped while snoozing (or ringing without snooze)
    cur(5'd7, 6'd1); step();
    cur(5'd7, 6'd0); step();
    chk_all("en.ring", 1'b1, 1'b0, ML, 5'd7, 6'd0);
    snz = 1; step(); snz = 0;
    chk("en.snz_alarm", int'(alarm), SNZ ? 0 : 1);
    chk("en.snz_active", int'(active), SNZ ? 1 : 0);
    en = 0; step();
    chk("en.off_alarm", int'(alarm), 0);
    chk("en.off_active", int'(active), 0);
    tick = 1; step(); tick = 0;
    chk("en.stays_off", int'(alarm), 0);

    // async reset while ringing at a reprogrammed time
    en = 1; cur(5'd12, 6'd0); step();
    set_h = 5'd6; set_m = 6'd30; set_ld = 1; step(); set_ld = 0;
    cur(5'd6, 6'd30); step();
    chk_all("rst.ring", 1'b1, 1'b0, ML, 5'd6, 6'd30);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 1'b0, 1'b0, ML, 5'd7, 6'd0);
    step();
    rst_n = 1'b1;
    cur(5'd7, 6'd0); step();
    chk("rst.idle_no_ring", int'(alarm), 0);
    step();
    chk("rst.armed_no_edge", int'(alarm), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
